cnn_csr_ctl: RTL

Parametrised Avalon-MM slave giving the HPS a control/status window onto the CNN accelerator top. It holds NUM_PTR 64-bit DDR pointer/parameter registers with explicit lo/hi word addressing. A launch state machine performs a start/busy/done handshake with the accelerator, with timeout and abort. It also provides sticky done/error status with write-1-to-clear, an interrupt, and a run-cycle counter. It sits between the HPS lightweight bridge and cnn_top, replacing the fixed five-register shift-in controller.

---
 rtl/cnn_csr_ctl_if.sv | 30 +++
 rtl/cnn_csr_ctl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_csr_ctl_if.sv
// Avalon-MM slave bus between the HPS lightweight bridge and the CNN
// control/status block.
interface cnn_csr_ctl_if #(
    parameter int ADDR_W = 6
);
    logic [ADDR_W-1:0] avs_address;
    logic              avs_write;
    logic              avs_read;
    logic [31:0]       avs_writedata;
    logic [31:0]       avs_readdata;
    logic              avs_waitrequest;

    modport master (
        output avs_address,
        output avs_write,
        output avs_read,
        output avs_writedata,
        input  avs_readdata,
        input  avs_waitrequest
    );

    modport slave (
        input  avs_address,
        input  avs_write,
        input  avs_read,
        input  avs_writedata,
        output avs_readdata,
        output avs_waitrequest
    );
endinterface

// File: rtl/cnn_csr_ctl.sv
// cnn_csr_ctl: HPS control/status window onto the CNN accelerator.
// Holds NUM_PTR 64-bit pointer registers (lo/hi word addressed), runs the
// start/busy/done launch handshake with timeout and abort, and keeps sticky
// DONE/ERR status, an interrupt and a saturating run-cycle counter.
module cnn_csr_ctl #(
    parameter int          NUM_PTR   = 5,
    parameter int          ADDR_W    = 6,
    parameter int          LAUNCH_TO = 1024,
    parameter logic [31:0] ID_VALUE  = 32'h434E_0002
) (
    input  logic                  clk,
    input  logic                  rstn,
    cnn_csr_ctl_if.slave          avs,
    output logic [NUM_PTR*64-1:0] ptr_o,
    output logic                  start,
    output logic                  abort,
    input  logic                  busy,
    input  logic                  done,
    output logic                  irq
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    localparam logic [31:0]       TO_LAST  = 32'(LAUNCH_TO - 1);
    localparam logic [31:0]       CYC_MAX  = 32'hFFFF_FFFF;
    localparam logic [31:0]       PTR_END  = 32'(4 + 2 * NUM_PTR);
    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_CYCLES = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_ID     = ADDR_W'(3);

    state_t      r_state;
    logic        r_start;
    logic        r_abort;
    logic        r_irq;
    logic        r_irq_en;
    logic        r_done;
    logic        r_err;
    logic [31:0] r_tocnt;
    logic [31:0] r_cycles;
    logic [31:0] r_rdata;
    logic [63:0] r_ptr [NUM_PTR];

    logic        w_wr_ctrl;
    logic        w_wr_status;
    logic        w_start_req;
    logic        w_abort_req;
    logic        w_active;
    logic        w_launch;
    logic        w_ptr_wr;
    logic        w_timeout;
    logic        w_done_set;
    logic        w_err_set;
    logic [31:0] w_rdata;

    // Decode bus writes and the hardware events that touch DONE/ERR.
    always_comb begin
        w_wr_ctrl   = avs.avs_write && (avs.avs_address == A_CTRL);
        w_wr_status = avs.avs_write && (avs.avs_address == A_STATUS);
        // ABORT wins over START when both arrive in one write.
        w_abort_req = w_wr_ctrl && avs.avs_writedata[2];
        w_start_req = w_wr_ctrl && avs.avs_writedata[0] && !avs.avs_writedata[2];
        w_active    = (r_state == ST_LAUNCH) || (r_state == ST_RUN);
        w_launch    = w_start_req && !w_active;
        w_ptr_wr    = avs.avs_write && (32'(avs.avs_address) >= 32'd4)
                      && (32'(avs.avs_address) < PTR_END);
        w_timeout   = (r_state == ST_LAUNCH) && !done && !busy
                      && (r_tocnt == TO_LAST) && !w_abort_req;
        w_done_set  = w_active && done && !w_abort_req;
        w_err_set   = w_timeout || (w_active && (w_ptr_wr || w_start_req));
    end

    // Launch state machine with registered start/abort and timeout counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_start <= 1'b0;
            r_abort <= 1'b0;
            r_tocnt <= 32'd0;
        end else begin
            r_abort <= w_abort_req;
            if (w_abort_req) begin
                r_state <= ST_IDLE;
                r_start <= 1'b0;
            end else begin
                case (r_state)
                    ST_LAUNCH: begin
                        r_tocnt <= r_tocnt + 32'd1;
                        if (done) begin
                            r_state <= ST_IDLE;
                            r_start <= 1'b0;
                        end else if (busy) begin
                            r_state <= ST_RUN;
                            r_start <= 1'b0;
                        end else if (r_tocnt == TO_LAST) begin
                            r_state <= ST_IDLE;
                            r_start <= 1'b0;
                        end else begin
                            r_state <= ST_LAUNCH;
                        end
                    end
                    ST_RUN: begin
                        r_start <= 1'b0;
                        if (done) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                    default: begin
                        // IDLE and the unused code 3 both behave as IDLE.
                        if (w_launch) begin
                            r_state <= ST_LAUNCH;
                            r_start <= 1'b1;
                            r_tocnt <= 32'd0;
                        end else begin
                            r_state <= ST_IDLE;
                            r_start <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    // Run-cycle counter: cleared on launch, saturating count while active.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cycles <= 32'd0;
        end else if (w_launch) begin
            r_cycles <= 32'd0;
        end else if (w_active && (r_cycles != CYC_MAX)) begin
            r_cycles <= r_cycles + 32'd1;
        end else begin
            r_cycles <= r_cycles;
        end
    end

    // CTRL IRQ_EN, sticky DONE/ERR (hardware set beats W1C) and the irq register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_irq_en <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_irq_en <= avs.avs_writedata[1];
            end else begin
                r_irq_en <= r_irq_en;
            end
            if (w_done_set) begin
                r_done <= 1'b1;
            end else if (w_wr_status && avs.avs_writedata[1]) begin
                r_done <= 1'b0;
            end else begin
                r_done <= r_done;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (w_wr_status && avs.avs_writedata[2]) begin
                r_err <= 1'b0;
            end else begin
                r_err <= r_err;
            end
            r_irq <= r_irq_en && (r_done || r_err);
        end
    end

    // Pointer registers; writes are accepted only while the engine is idle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < NUM_PTR; k++) begin
                r_ptr[k] <= 64'd0;
            end
        end else if (w_ptr_wr && !w_active) begin
            for (int k = 0; k < NUM_PTR; k++) begin
                if (avs.avs_address == ADDR_W'(4 + 2 * k)) begin
                    r_ptr[k][31:0] <= avs.avs_writedata;
                end else if (avs.avs_address == ADDR_W'(5 + 2 * k)) begin
                    r_ptr[k][63:32] <= avs.avs_writedata;
                end else begin
                    r_ptr[k] <= r_ptr[k];
                end
            end
        end else begin
            for (int k = 0; k < NUM_PTR; k++) begin
                r_ptr[k] <= r_ptr[k];
            end
        end
    end

    // Read-data mux; unmapped addresses return 0.
    always_comb begin
        w_rdata = 32'd0;
        case (avs.avs_address)
            A_CTRL:   w_rdata = {30'd0, r_irq_en, 1'b0};
            A_STATUS: w_rdata = {26'd0, r_state, busy, r_err, r_done, w_active};
            A_CYCLES: w_rdata = r_cycles;
            A_ID:     w_rdata = ID_VALUE;
            default: begin
                for (int k = 0; k < NUM_PTR; k++) begin
                    if (avs.avs_address == ADDR_W'(4 + 2 * k)) begin
                        w_rdata = r_ptr[k][31:0];
                    end else if (avs.avs_address == ADDR_W'(5 + 2 * k)) begin
                        w_rdata = r_ptr[k][63:32];
                    end else begin
                        w_rdata = w_rdata;
                    end
                end
            end
        endcase
    end

    // Registered read data, updated only on a read strobe.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rdata <= 32'd0;
        end else if (avs.avs_read) begin
            r_rdata <= w_rdata;
        end else begin
            r_rdata <= r_rdata;
        end
    end

    for (genvar g = 0; g < NUM_PTR; g++) begin : g_ptr_o
        assign ptr_o[64*g +: 64] = r_ptr[g];
    end

    assign avs.avs_readdata    = r_rdata;
    assign avs.avs_waitrequest = 1'b0;
    assign start               = r_start;
    assign abort               = r_abort;
    assign irq                 = r_irq;
endmodule
